alu_seq: RTL and testbench

Sequential, handshaked 8-bit ALU that is the responding end of the OPCODE/A/B → RESULT interface the team's ALU stimulus benches drive. It accepts one operation per valid/ready transfer, executes it in one cycle or, for multiply, over eight shift-add cycles. It then holds the result with status flags until the consumer takes it. It sits between an instruction/stimulus source and a result sink, for example a register-file writeback or a bench scoreboard.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for the sequential ALU.
//   opcode[3:0], a[7:0], b[7:0], in_valid : request from the source
//   in_ready                              : ALU can take a request
//   result[7:0], carry, zero, out_valid   : completed operation
//   out_ready                             : sink takes the result
// The master modport is the source/sink side; slave is the ALU side.
interface alu_seq_if;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output opcode, a, b, in_valid, out_ready,
        input  in_ready, result, carry, zero, out_valid
    );

    modport slave (
        input  opcode, a, b, in_valid, out_ready,
        output in_ready, result, carry, zero, out_valid
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked 8-bit ALU. One operation is accepted per valid/ready
// transfer in IDLE. Single-cycle opcodes complete on the accept edge; MUL
// (opcode 10) runs eight shift-add cycles. The result and flags are held
// in DONE until the sink takes them.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, highest priority
//   bus : alu_seq_if.slave (opcode/a/b/in_valid in, in_ready out,
//         result/carry/zero/out_valid out, out_ready in)
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    alu_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [2:0]  k_r;
    logic [15:0] acc_r;
    logic [7:0]  result_r;
    logic        carry_r;
    logic        zero_r;
    logic        out_valid_r;
    logic        in_ready_r;

    logic [8:0]  sum_s;
    logic [7:0]  alu_res_s;
    logic        alu_carry_s;
    logic [15:0] mul_add_s;
    logic [15:0] acc_next_s;

    // Single-cycle result computed straight from the presented operands so it
    // can be loaded on the accept edge.
    always_comb begin
        sum_s       = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res_s   = 8'd0;
        alu_carry_s = 1'b0;
        case (bus.opcode)
            4'd0: begin
                alu_res_s   = sum_s[7:0];
                alu_carry_s = sum_s[8];
            end
            4'd1: begin
                alu_res_s   = bus.a - bus.b;
                alu_carry_s = (bus.a < bus.b);
            end
            4'd2: alu_res_s = bus.a & bus.b;
            4'd3: alu_res_s = bus.a | bus.b;
            4'd4: alu_res_s = bus.a ^ bus.b;
            4'd5: alu_res_s = ~bus.a;
            4'd6: alu_res_s = bus.a << bus.b[2:0];
            4'd7: alu_res_s = bus.a >> bus.b[2:0];
            4'd8: begin
                alu_res_s   = bus.a + 8'd1;
                alu_carry_s = (bus.a == 8'd255);
            end
            4'd9: begin
                alu_res_s   = bus.a - 8'd1;
                alu_carry_s = (bus.a == 8'd0);
            end
            4'd11: alu_res_s = (bus.a < bus.b) ? 8'd1 : 8'd0;
            // MUL is handled by the shift-add path; 12-15 are reserved.
            default: begin
                alu_res_s   = 8'd0;
                alu_carry_s = 1'b0;
            end
        endcase
    end

    // One shift-add step: partial product A<<k when B[k] is set.
    always_comb begin
        mul_add_s = 16'd0;
        if (b_r[k_r]) begin
            mul_add_s = {8'd0, a_r} << k_r;
        end else begin
            mul_add_s = 16'd0;
        end
        acc_next_s = acc_r + mul_add_s;
    end

    // Control FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= 8'd0;
            b_r         <= 8'd0;
            k_r         <= 3'd0;
            acc_r       <= 16'd0;
            result_r    <= 8'd0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        in_ready_r <= 1'b0;
                        if (bus.opcode == 4'd10) begin
                            acc_r   <= 16'd0;
                            k_r     <= 3'd0;
                            state_r <= ST_MUL;
                        end else begin
                            result_r    <= alu_res_s;
                            carry_r     <= alu_carry_s;
                            zero_r      <= (alu_res_s == 8'd0);
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r <= acc_next_s;
                    k_r   <= k_r + 3'd1;
                    // Last step: load the product from the updated accumulator.
                    if (k_r == 3'd7) begin
                        result_r    <= acc_next_s[7:0];
                        carry_r     <= |acc_next_s[15:8];
                        zero_r      <= (acc_next_s[7:0] == 8'd0);
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.result    = result_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = zero_r;
    assign bus.out_valid = out_valid_r;
    assign bus.in_ready  = in_ready_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq. Expected results come from a
// small behavioural model and are queued when a request is driven, then
// popped and compared when the ALU presents out_valid.
module tb_alu_seq;

    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       zero;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    alu_seq_if bus();

    alu_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of one operation.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        exp_t        r;
        logic [8:0]  s;
        logic [15:0] p;
        r = '0;
        case (op)
            4'd0: begin s = {1'b0, x} + {1'b0, y}; r.result = s[7:0]; r.carry = s[8]; end
            4'd1: begin r.result = x - y; r.carry = (x < y); end
            4'd2: r.result = x & y;
            4'd3: r.result = x | y;
            4'd4: r.result = x ^ y;
            4'd5: r.result = ~x;
            4'd6: r.result = x << y[2:0];
            4'd7: r.result = x >> y[2:0];
            4'd8: begin r.result = x + 8'd1; r.carry = (x == 8'd255); end
            4'd9: begin r.result = x - 8'd1; r.carry = (x == 8'd0); end
            4'd10: begin p = {8'd0, x} * {8'd0, y}; r.result = p[7:0]; r.carry = (p > 16'd255); end
            4'd11: r.result = (x < y) ? 8'd1 : 8'd0;
            default: r.result = 8'd0;
        endcase
        r.zero = (r.result == 8'd0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        bus.opcode   = op;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count edges since the accept edge until out_valid, bounded by max_edges.
    task automatic wait_valid(input int max_edges, output int n);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < max_edges) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.opcode = 4'd0; bus.a = 8'd1; bus.b = 8'd1;
        bus.out_ready = 1'b0;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.result !== 8'd0) begin errors++; $display("FAIL reset_result got %0d want 0", bus.result); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.carry !== 1'b0 || bus.zero !== 1'b0) begin errors++; $display("FAIL reset_flags got c%b z%b want c0 z0", bus.carry, bus.zero); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept got out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_sweep();
        logic [7:0] table_res [12] = '{8'd47, 8'd37, 8'd0, 8'd47, 8'd47, 8'd213,
                                       8'd64, 8'd1, 8'd43, 8'd41, 8'd210, 8'd0};
        int   n;
        exp_t e;
        bus.out_ready = 1'b1;
        for (int op = 0; op < 12; op++) begin
            sb.push_back(model(op[3:0], 8'd42, 8'd5));
            issue(op[3:0], 8'd42, 8'd5);
            wait_valid(12, n);
            checks++; if (n !== ((op == 10) ? 9 : 1)) begin errors++; $display("FAIL sweep_latency op %0d got %0d want %0d", op, n, (op == 10) ? 9 : 1); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid op %0d got %b want 1", op, bus.out_valid); end
            if (sb.size() == 0) begin
                checks++; errors++; $display("FAIL sweep_scoreboard_empty op %0d got 0 entries want 1", op);
            end else begin
                e = sb.pop_front();
                checks++; if (bus.result !== e.result || bus.carry !== e.carry || bus.zero !== e.zero) begin errors++; $display("FAIL sweep_model op %0d got %0d c%b z%b want %0d c%b z%b", op, bus.result, bus.carry, bus.zero, e.result, e.carry, e.zero); end
            end
            checks++; if (bus.result !== table_res[op]) begin errors++; $display("FAIL sweep_table op %0d got %0d want %0d", op, bus.result, table_res[op]); end
            tick();
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL sweep_release op %0d got v%b r%b want v0 r1", op, bus.out_valid, bus.in_ready); end
        end
    endtask

    task automatic test_flags();
        logic [3:0] ops [4] = '{4'd0, 4'd1, 4'd4, 4'd13};
        logic [7:0] xa  [4] = '{8'd200, 8'd5, 8'd42, 8'd7};
        logic [7:0] yb  [4] = '{8'd100, 8'd42, 8'd42, 8'd9};
        logic [7:0] rr  [4] = '{8'd44, 8'd219, 8'd0, 8'd0};
        logic       cc  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       zz  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int   n;
        exp_t e;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model(ops[i], xa[i], yb[i]));
            issue(ops[i], xa[i], yb[i]);
            wait_valid(4, n);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flags_valid case %0d got %b want 1", i, bus.out_valid); end
            if (sb.size() == 0) begin
                checks++; errors++; $display("FAIL flags_scoreboard_empty case %0d", i);
            end else begin
                e = sb.pop_front();
                checks++; if (bus.result !== e.result || bus.carry !== e.carry || bus.zero !== e.zero) begin errors++; $display("FAIL flags_model case %0d got %0d c%b z%b want %0d c%b z%b", i, bus.result, bus.carry, bus.zero, e.result, e.carry, e.zero); end
            end
            checks++; if (bus.result !== rr[i] || bus.carry !== cc[i] || bus.zero !== zz[i]) begin errors++; $display("FAIL flags_table case %0d got %0d c%b z%b want %0d c%b z%b", i, bus.result, bus.carry, bus.zero, rr[i], cc[i], zz[i]); end
            tick();
        end
    endtask

    task automatic test_mul();
        logic early;
        logic busy_ready;
        exp_t e;
        early = 1'b0;
        busy_ready = 1'b0;
        bus.out_ready = 1'b1;
        sb.push_back(model(4'd10, 8'd20, 8'd13));
        issue(4'd10, 8'd20, 8'd13);
        for (int i = 1; i < 9; i++) begin
            if (bus.out_valid !== 1'b0) early = 1'b1;
            if (bus.in_ready !== 1'b0) busy_ready = 1'b1;
            tick();
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL mul_early_valid got 1 want 0"); end
        checks++; if (busy_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready got 1 want 0"); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mul_valid_edge9 got %b want 1", bus.out_valid); end
        checks++; if (bus.result !== 8'd4 || bus.carry !== 1'b1) begin errors++; $display("FAIL mul_result got %0d c%b want 4 c1", bus.result, bus.carry); end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++; if (bus.result !== e.result || bus.carry !== e.carry || bus.zero !== e.zero) begin errors++; $display("FAIL mul_model got %0d c%b z%b want %0d c%b z%b", bus.result, bus.carry, bus.zero, e.result, e.carry, e.zero); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        bus.out_ready = 1'b0;
        sb.push_back(model(4'd0, 8'd1, 8'd2));
        issue(4'd0, 8'd1, 8'd2);
        e = sb.pop_front();
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== e.result) begin errors++; $display("FAIL bp_first got v%b %0d want v1 %0d", bus.out_valid, bus.result, e.result); end
        // A new request waits while the result is held.
        bus.opcode = 4'd0; bus.a = 8'd10; bus.b = 8'd10; bus.in_valid = 1'b1;
        sb.push_back(model(4'd0, 8'd10, 8'd10));
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.result !== 8'd3 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold cycle %0d got v%b %0d r%b want v1 3 r0", i, bus.out_valid, bus.result, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v%b r%b want v0 r1", bus.out_valid, bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== e.result) begin errors++; $display("FAIL bp_second got v%b %0d want v1 %0d", bus.out_valid, bus.result, e.result); end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        logic seen;
        int   n;
        exp_t e;
        seen = 1'b0;
        bus.out_ready = 1'b1;
        issue(4'd10, 8'd20, 8'd13);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmul_handshake got v%b r%b want v0 r1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.result !== 8'd0 || bus.carry !== 1'b0 || bus.zero !== 1'b0) begin errors++; $display("FAIL rmul_outputs got %0d c%b z%b want 0 c0 z0", bus.result, bus.carry, bus.zero); end
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmul_stray_valid got 1 want 0"); end
        sb.push_back(model(4'd0, 8'd1, 8'd1));
        issue(4'd0, 8'd1, 8'd1);
        wait_valid(4, n);
        e = sb.pop_front();
        checks++; if (bus.out_valid !== 1'b1 || bus.result !== 8'd2 || bus.result !== e.result) begin errors++; $display("FAIL rmul_add got v%b %0d want v1 2", bus.out_valid, bus.result); end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] x;
        bus.out_ready = 1'b1;
        bus.opcode = 4'd4; bus.a = 8'd0; bus.b = 8'h0F; bus.in_valid = 1'b1;
        sb.push_back(model(4'd4, 8'd0, 8'h0F));
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid item %0d got %b want 1", i, bus.out_valid); end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++; if (bus.result !== e.result || bus.zero !== e.zero) begin errors++; $display("FAIL b2b_result item %0d got %0d z%b want %0d z%b", i, bus.result, bus.zero, e.result, e.zero); end
            end
            if (i < 3) begin
                x = 8'(8'd51 * (i + 1));
                bus.a = x;
                sb.push_back(model(4'd4, x, 8'h0F));
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap item %0d got %b want 0", i, bus.out_valid); end
            if (i < 3) tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.opcode = 4'd0;
        bus.a = 8'd0;
        bus.b = 8'd0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_sweep();
        test_flags();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
